// File: rtl/vpu_bg_line_engine.sv
// Background line engine: composites NUM_LAYERS tilemap layers into one
// line of ARGB pixels via a four-stage RAM pipeline (map/tile/palette).
// Ports: clk, rst_n (async, active-low); start/y/backdrop line request;
// busy/done status; param_*, map_*, tile_*, pal_* 1-cycle-latency RAM
// read ports; line_we/line_addr/line_din line-buffer write port.
module vpu_bg_line_engine #(
    parameter int NUM_LAYERS = 4,
    parameter int LINE_W     = 320,
    parameter int PARAM_BASE = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [8:0]  y,
    input  logic [31:0] backdrop,
    output logic        busy,
    output logic        done,
    output logic        param_en,
    output logic [9:0]  param_addr,
    input  logic [31:0] param_dout,
    output logic        map_en,
    output logic [15:0] map_addr,
    input  logic [15:0] map_dout,
    output logic        tile_en,
    output logic [12:0] tile_addr,
    input  logic [7:0]  tile_dout,
    output logic        pal_en,
    output logic [9:0]  pal_addr,
    input  logic [31:0] pal_dout,
    output logic        line_we,
    output logic [8:0]  line_addr,
    output logic [31:0] line_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RENDER,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [4:0] LOAD_RD = 5'(2 * NUM_LAYERS);
    localparam logic [2:0] LAST_L  = 3'(NUM_LAYERS - 1);
    localparam logic [8:0] LAST_X  = 9'(LINE_W - 1);

    state_t      r_state;
    state_t      w_next;

    logic [8:0]  r_y;
    logic [4:0]  r_cnt;
    logic [8:0]  r_x;
    logic [2:0]  r_l;

    // per-layer parameters, frozen after LOAD
    logic [7:0]  r_en;
    logic [7:0]  r_hf;
    logic [7:0]  r_vf;
    logic [7:0]  r_pm;
    logic [8:0]  r_sx [8];
    logic [8:0]  r_sy [8];
    logic [3:0]  r_mb [8];
    logic [1:0]  r_pb [8];

    // pipeline stage registers
    logic        r_s1_v;
    logic [8:0]  r_s1_x;
    logic [2:0]  r_s1_l;
    logic [2:0]  r_s1_wx;
    logic [2:0]  r_s1_wy;
    logic        r_s2_v;
    logic [8:0]  r_s2_x;
    logic [2:0]  r_s2_l;
    logic [3:0]  r_s2_pno;
    logic        r_s3_v;
    logic [8:0]  r_s3_x;
    logic [2:0]  r_s3_l;
    logic        r_s3_op;
    logic [31:0] r_acc;

    logic [4:0]  w_cm1;
    logic [2:0]  w_li;
    logic        w_last_pair;
    logic        w_s0_v;
    logic [8:0]  w_wx;
    logic [8:0]  w_wy;
    logic [2:0]  w_px;
    logic [2:0]  w_py;
    logic        w_s2_clr;
    logic [31:0] w_base;
    logic [31:0] w_pix;

    // word returned this cycle belongs to the read issued at r_cnt-1
    assign w_cm1       = r_cnt - 5'd1;
    assign w_li        = w_cm1[3:1];
    assign w_last_pair = (r_x == LAST_X) && (r_l == LAST_L);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   if (r_cnt == LOAD_RD) w_next = S_RENDER;
            S_RENDER: if (w_last_pair) w_next = S_DRAIN;
            S_DRAIN:  if (r_cnt == 5'd2) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        param_en   = (r_state == S_LOAD) && (r_cnt < LOAD_RD);
        param_addr = '0;
        if (param_en) param_addr = 10'(PARAM_BASE) + {5'd0, r_cnt};
    end

    // S0: scrolled coordinates and map fetch
    assign w_s0_v   = (r_state == S_RENDER);
    assign w_wx     = r_x - r_sx[r_l];
    assign w_wy     = r_y - r_sy[r_l];
    assign map_en   = w_s0_v;
    assign map_addr = w_s0_v ? {r_mb[r_l], w_wy[8:3], w_wx[8:3]} : '0;

    // S1: tile fetch; the 13-bit tile port reaches tiles 0..127 only
    assign w_px      = r_s1_wx ^ {3{r_hf[r_s1_l]}};
    assign w_py      = r_s1_wy ^ {3{r_vf[r_s1_l]}};
    assign tile_en   = r_s1_v;
    assign tile_addr = r_s1_v ? {map_dout[6:0], w_py, w_px} : '0;

    // S2: palette fetch, transparency decided on the raw index
    always_comb begin
        pal_en   = r_s2_v;
        pal_addr = '0;
        w_s2_clr = 1'b0;
        if (r_pm[r_s2_l]) begin
            w_s2_clr = (tile_dout[3:0] == 4'd0);
            if (r_s2_v) pal_addr = {r_pb[r_s2_l], r_s2_pno, tile_dout[3:0]};
        end else begin
            w_s2_clr = (tile_dout == 8'd0);
            if (r_s2_v) pal_addr = {r_pb[r_s2_l], tile_dout};
        end
    end

    // S3: composite; layer 0 restarts from backdrop
    assign w_base    = (r_s3_l == 3'd0) ? backdrop : r_acc;
    assign w_pix     = r_s3_op ? pal_dout : w_base;
    assign line_we   = r_s3_v && (r_s3_l == LAST_L);
    assign line_addr = line_we ? r_s3_x : '0;
    assign line_din  = line_we ? w_pix : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_y     <= '0;
            r_cnt   <= '0;
            r_x     <= '0;
            r_l     <= '0;
            r_en    <= '0;
            r_hf    <= '0;
            r_vf    <= '0;
            r_pm    <= '0;
            for (int i = 0; i < 8; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
                r_mb[i] <= '0;
                r_pb[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (start) r_y <= y;
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt != 5'd0) begin
                        if (!w_cm1[0]) begin
                            r_en[w_li] <= param_dout[31];
                            r_hf[w_li] <= param_dout[27];
                            r_vf[w_li] <= param_dout[26];
                            r_sx[w_li] <= param_dout[24:16];
                            r_sy[w_li] <= param_dout[8:0];
                        end else begin
                            r_mb[w_li] <= param_dout[27:24];
                            r_pm[w_li] <= param_dout[6];
                            r_pb[w_li] <= param_dout[5:4];
                        end
                    end
                    if (r_cnt == LOAD_RD) begin
                        r_cnt <= '0;
                        r_x   <= '0;
                        r_l   <= '0;
                    end
                end
                S_RENDER: begin
                    if (r_l == LAST_L) begin
                        r_l <= '0;
                        r_x <= r_x + 9'd1;
                    end else begin
                        r_l <= r_l + 3'd1;
                    end
                end
                S_DRAIN: r_cnt <= r_cnt + 5'd1;
                default: r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_x   <= '0;
            r_s1_l   <= '0;
            r_s1_wx  <= '0;
            r_s1_wy  <= '0;
            r_s2_v   <= 1'b0;
            r_s2_x   <= '0;
            r_s2_l   <= '0;
            r_s2_pno <= '0;
            r_s3_v   <= 1'b0;
            r_s3_x   <= '0;
            r_s3_l   <= '0;
            r_s3_op  <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_s1_v   <= w_s0_v;
            r_s1_x   <= r_x;
            r_s1_l   <= r_l;
            r_s1_wx  <= w_wx[2:0];
            r_s1_wy  <= w_wy[2:0];
            r_s2_v   <= r_s1_v;
            r_s2_x   <= r_s1_x;
            r_s2_l   <= r_s1_l;
            r_s2_pno <= map_dout[15:12];
            r_s3_v   <= r_s2_v;
            r_s3_x   <= r_s2_x;
            r_s3_l   <= r_s2_l;
            r_s3_op  <= r_en[r_s2_l] && !w_s2_clr;
            if (r_s3_v) r_acc <= w_pix;
        end
    end

endmodule

// File: tb/tb_vpu_bg_line_engine.sv
// Bench for vpu_bg_line_engine: RAM models, reference compositor and
// scoreboard of expected line-buffer writes.
module tb_vpu_bg_line_engine;

    localparam int NL = 4;
    localparam int LW = 320;
    localparam int PB = 640;
    localparam int DONE_CYC = 2 * NL + 1 + LW * NL + 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  y = '0;
    logic [31:0] backdrop = '0;
    logic        busy, done;
    logic        param_en, map_en, tile_en, pal_en, line_we;
    logic [9:0]  param_addr, pal_addr;
    logic [15:0] map_addr;
    logic [12:0] tile_addr;
    logic [8:0]  line_addr;
    logic [31:0] line_din;
    logic [31:0] param_dout = '0;
    logic [15:0] map_dout = '0;
    logic [7:0]  tile_dout = '0;
    logic [31:0] pal_dout = '0;

    logic [31:0] param_mem [0:1023];
    logic [15:0] map_mem [0:65535];
    logic [7:0]  tile_mem [0:8191];
    logic [31:0] pal_mem [0:1023];
    logic [31:0] line_seen [0:511];
    logic [40:0] q_exp [$];

    logic [15:0] first_map;
    logic [12:0] first_tile;
    logic [9:0]  first_pal;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vpu_bg_line_engine #(
        .NUM_LAYERS(NL),
        .LINE_W(LW),
        .PARAM_BASE(PB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .y(y),
        .backdrop(backdrop),
        .busy(busy),
        .done(done),
        .param_en(param_en),
        .param_addr(param_addr),
        .param_dout(param_dout),
        .map_en(map_en),
        .map_addr(map_addr),
        .map_dout(map_dout),
        .tile_en(tile_en),
        .tile_addr(tile_addr),
        .tile_dout(tile_dout),
        .pal_en(pal_en),
        .pal_addr(pal_addr),
        .pal_dout(pal_dout),
        .line_we(line_we),
        .line_addr(line_addr),
        .line_din(line_din)
    );

    always @(posedge clk) begin
        if (param_en) param_dout <= param_mem[param_addr];
        if (map_en) map_dout <= map_mem[map_addr];
        if (tile_en) tile_dout <= tile_mem[tile_addr];
        if (pal_en) pal_dout <= pal_mem[pal_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < 1024; i++) begin
            param_mem[i] = '0;
            pal_mem[i] = '0;
        end
        for (int i = 0; i < 65536; i++) map_mem[i] = '0;
        for (int i = 0; i < 8192; i++) tile_mem[i] = '0;
    endtask

    task automatic set_layer(input int l, input bit en, input bit hf,
                             input bit vf, input logic [8:0] sx,
                             input logic [8:0] sy, input logic [3:0] mb,
                             input bit pm, input logic [1:0] pb);
        param_mem[PB + 2 * l] = {en, 3'b0, hf, vf, 1'b0, sx, 7'b0, sy};
        param_mem[PB + 2 * l + 1] = {4'b0, mb, 17'b0, pm, pb, 4'b0};
    endtask

    function automatic logic [31:0] model_pix(input logic [8:0] x,
                                              input logic [8:0] yv,
                                              input logic [31:0] bd);
        logic [31:0] acc, w0, w1;
        logic [8:0]  wx, wy;
        logic [15:0] ma, md, tfull;
        logic [2:0]  px, py;
        logic [7:0]  idx;
        logic [9:0]  pa;
        bit          clr;
        acc = bd;
        for (int l = 0; l < NL; l++) begin
            w0 = param_mem[PB + 2 * l];
            w1 = param_mem[PB + 2 * l + 1];
            if (w0[31]) begin
                wx = x - w0[24:16];
                wy = yv - w0[8:0];
                ma = {w1[27:24], wy[8:3], wx[8:3]};
                md = map_mem[ma];
                px = wx[2:0] ^ {3{w0[27]}};
                py = wy[2:0] ^ {3{w0[26]}};
                tfull = {md[9:0], py, px};
                idx = tile_mem[tfull[12:0]];
                if (w1[6]) begin
                    clr = (idx[3:0] == 4'd0);
                    pa = {w1[5:4], md[15:12], idx[3:0]};
                end else begin
                    clr = (idx == 8'd0);
                    pa = {w1[5:4], idx};
                end
                if (!clr) acc = pal_mem[pa];
            end
        end
        return acc;
    endfunction

    task automatic run_line(input logic [8:0] yv, input logic [31:0] bd,
                            input bit corrupt, input bit abort);
        logic [40:0] e;
        int done_at = 0;
        int n_wr = 0;
        int quiet = 0;
        bit aborted = 0;
        bit gm = 0, gt = 0, gp = 0;
        q_exp.delete();
        for (int x = 0; x < LW; x++)
            q_exp.push_back({9'(x), model_pix(9'(x), yv, bd)});
        for (int i = 0; i < 512; i++) line_seen[i] = '0;
        @(negedge clk);
        y = yv;
        backdrop = bd;
        start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 50) start = 1'b1;
            if (n == 51) start = 1'b0;
            if (corrupt && n == 20)
                set_layer(1, 1, 0, 0, 9'd0, 9'd0, 4'd2, 0, 2'd0);
            if (map_en && !gm) begin gm = 1; first_map = map_addr; end
            if (tile_en && !gt) begin gt = 1; first_tile = tile_addr; end
            if (pal_en && !gp) begin gp = 1; first_pal = pal_addr; end
            if (line_we) begin
                n_wr++;
                line_seen[line_addr] = line_din;
                if (q_exp.size() == 0) begin
                    chk("extra_write", 64'(line_addr), 64'h1ff);
                end else begin
                    e = q_exp.pop_front();
                    chk("wr_addr", 64'(line_addr), 64'(e[40:32]));
                    chk("wr_data", 64'(line_din), 64'(e[31:0]));
                end
                if (abort && line_addr == 9'd100) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_we", 64'(line_we), 64'd0);
                    chk("abort_busy", 64'(busy), 64'd0);
                    aborted = 1;
                    break;
                end
            end
            if (done) begin
                done_at = n;
                break;
            end
        end
        if (aborted) begin
            q_exp.delete();
            repeat (3) @(negedge clk);
            chk("abort_rst_en", 64'({map_en, tile_en, pal_en, done}), 64'd0);
            rst_n = 1'b1;
            for (int n = 0; n < 1400; n++) begin
                @(negedge clk);
                if (done || line_we || busy) quiet++;
            end
            chk("abort_quiet", 64'(quiet), 64'd0);
        end else begin
            chk("done_cycle", 64'(done_at), 64'(DONE_CYC));
            chk("write_count", 64'(n_wr), 64'(LW));
            chk("sb_empty", 64'(q_exp.size()), 64'd0);
            @(negedge clk);
            chk("idle_after", 64'({busy, done}), 64'd0);
        end
    endtask

    initial begin
        clear_all();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_en", 64'({param_en, map_en, tile_en, pal_en}), 64'd0);
        chk("rst_we", 64'(line_we), 64'd0);
        chk("rst_paddr", 64'(param_addr), 64'd0);
        chk("rst_maddr", 64'(map_addr), 64'd0);
        chk("rst_taddr", 64'(tile_addr), 64'd0);
        chk("rst_laddr", 64'({line_addr, line_din}), 64'd0);
        rst_n = 1'b1;

        // all layers disabled
        run_line(9'd0, 32'hFF102030, 0, 0);
        chk("bd_x0", 64'(line_seen[0]), 64'hFF102030);
        chk("bd_x319", 64'(line_seen[319]), 64'hFF102030);

        // single scrolled layer; params rewritten mid-line
        clear_all();
        set_layer(0, 1, 0, 0, 9'd5, 9'd0, 4'd0, 0, 2'd0);
        map_mem[0] = 16'h0001;
        tile_mem[64] = 8'd3;
        pal_mem[3] = 32'hFFFF0000;
        for (int k = 0; k < 64; k++) begin
            map_mem[16'h2000 + k] = 16'h0002;
            tile_mem[128 + k] = 8'd1;
        end
        pal_mem[1] = 32'hDEADBEEF;
        run_line(9'd0, 32'hFF000000, 1, 0);
        chk("l0_x5", 64'(line_seen[5]), 64'hFFFF0000);
        chk("l0_x4", 64'(line_seen[4]), 64'hFF000000);

        // layer priority
        clear_all();
        set_layer(0, 1, 0, 0, 9'd0, 9'd0, 4'd0, 0, 2'd0);
        set_layer(2, 1, 0, 0, 9'd0, 9'd0, 4'd1, 0, 2'd1);
        map_mem[16'h0041] = 16'h0003;
        map_mem[16'h1041] = 16'h0004;
        tile_mem[194] = 8'h10;
        tile_mem[258] = 8'h11;
        pal_mem[10'h010] = 32'hFF00FF00;
        pal_mem[10'h111] = 32'hFF0000FF;
        run_line(9'd8, 32'hFF808080, 0, 0);
        chk("prio_front", 64'(line_seen[10]), 64'hFF0000FF);
        tile_mem[258] = 8'h00;
        run_line(9'd8, 32'hFF808080, 0, 0);
        chk("prio_clear", 64'(line_seen[10]), 64'hFF00FF00);

        // scroll wrap, hflip, palette mode 1
        clear_all();
        set_layer(0, 1, 1, 0, 9'd511, 9'd0, 4'd3, 1, 2'd2);
        map_mem[16'h3080] = 16'h7002;
        tile_mem[166] = 8'h25;
        pal_mem[10'h275] = 32'hFF123456;
        run_line(9'd20, 32'hFF000000, 0, 0);
        chk("wrap_map", 64'(first_map), 64'h3080);
        chk("hflip_px", 64'(first_tile[2:0]), 64'd6);
        chk("pm1_pal", 64'(first_pal), 64'h275);
        chk("pm1_x0", 64'(line_seen[0]), 64'hFF123456);

        // reset mid-line, then a clean line
        run_line(9'd20, 32'hFF000000, 0, 1);
        run_line(9'd20, 32'hFF000000, 0, 0);
        chk("post_rst_x0", 64'(line_seen[0]), 64'hFF123456);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vpu_bg_line_engine.md
VPU_BG_LINE_ENGINE -- requirements
Module: vpu_bg_line_engine

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, with legal range 1..8; it sets the number of BG layers composited per line.
REQ-002 SHALL have parameter LINE_W, default 320, giving the number of pixels rendered per line.
REQ-003 SHALL have parameter PARAM_BASE, default 640, giving the word address of the layer-0 parameters in param RAM.
REQ-004 SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- start  in  1  one-cycle pulse that begins rendering one line.
- y  in  9  screen line, sampled when start is accepted.
- backdrop  in  32  ARGB colour used where every layer is transparent.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final line-buffer write.
- param_en/param_addr/param_dout  out/out/in  1/10/32  param RAM port.
- map_en/map_addr/map_dout  out/out/in  1/16/16  tilemap RAM port.
- tile_en/tile_addr/tile_dout  out/out/in  1/13/8  tile RAM port.
- pal_en/pal_addr/pal_dout  out/out/in  1/10/32  palette RAM port.
- line_we/line_addr/line_din  out/out/out  1/9/32  line-buffer write port.
REQ-005 All RAMs SHALL have a read latency of exactly 1 cycle: dout is valid in the cycle after en is high with addr.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, RENDER, DRAIN, DONE.
REQ-007 In IDLE, start=1 SHALL latch y and move to LOAD. Start in any other state SHALL be ignored.
REQ-008 LOAD SHALL issue 2*NUM_LAYERS consecutive reads at addresses PARAM_BASE+2*L+w, with w=0 then w=1 for each layer L.
REQ-009 LOAD SHALL capture each returned word one cycle after its read, and SHALL last 2*NUM_LAYERS+1 cycles.
REQ-010 Word0 fields: [31] enable, [27] hflip, [26] vflip, [24:16] scroll_x, [8:0] scroll_y.
REQ-011 Word1 fields: [27:24] map_bank, [6] pal_mode, [5:4] pal_bank.
REQ-012 RENDER SHALL issue one (x, L) pair per cycle: x ascending from 0 to LINE_W-1, with L cycling 0..NUM_LAYERS-1 inside each x. RENDER lasts LINE_W*NUM_LAYERS cycles.
REQ-013 Stage S0 SHALL compute wx=(x-scroll_x) mod 512 and wy=(y-scroll_y) mod 512 (9-bit wrap), and SHALL drive map_addr={map_bank, wy[8:3], wx[8:3]}.
REQ-014 Stage S1 SHALL compute px=wx[2:0]^{3{hflip}} and py=wy[2:0]^{3{vflip}}, and SHALL drive tile_addr={map_dout[9:0], py, px}.
REQ-015 S1 SHALL carry map_dout[15:12] forward as pal_no.
REQ-016 Stage S2 SHALL form idx=tile_dout and drive the palette address as follows:
- pal_mode=0: pal_addr={pal_bank, idx}; the pixel is transparent when idx==0.
- pal_mode=1: pal_addr={pal_bank, pal_no, idx[3:0]}; the pixel is transparent when idx[3:0]==0.
REQ-017 Stage S3 SHALL composite. For L=0 the accumulator SHALL start at backdrop. An enabled, opaque layer SHALL replace the accumulator with pal_dout. Disabled or transparent layers SHALL leave it unchanged. Higher L is in front.
REQ-018 When S3 processes L=NUM_LAYERS-1, the block SHALL pulse line_we with line_addr=x and line_din equal to the final accumulator.
REQ-019 Exactly LINE_W writes SHALL occur per line, in ascending x order.
REQ-020 DRAIN SHALL last 3 cycles to flush S1..S3. DONE SHALL assert done for 1 cycle and then return to IDLE.
REQ-021 busy SHALL be 1 in LOAD, RENDER, DRAIN and DONE, and 0 in IDLE.
REQ-022 The done pulse SHALL occur exactly 2*NUM_LAYERS+1+LINE_W*NUM_LAYERS+4 cycles after the cycle in which start is sampled.
REQ-023 map_en, tile_en and pal_en SHALL be high only while their pipeline stage holds a valid pair. param_en SHALL be high only during LOAD read issue.
REQ-024 Parameters SHALL stay frozen during RENDER; param RAM changes during RENDER SHALL NOT affect the line.

Reset
REQ-025 While rst_n=0: FSM in IDLE, all stage-valid flags cleared, and busy, done, all *_en and line_we at 0. Address, data and parameter registers SHALL be 0.
REQ-026 Reset asserted mid-line SHALL abort immediately: no further line_we, and no done for that line.
REQ-027 After reset deasserts, the next start SHALL render a full, correct line.

Verification
REQ-028 Default parameters, all layers disabled, backdrop=32'hFF102030, start -> 320 writes of FF102030 at x=0..319, and done at cycle 1293.
REQ-029 Layer 0 enabled with scroll_x=5, map tile 1, pixel idx=3 at tile px=0, pal_mode=0, pal_bank=0, pal[3]=FFFF0000 -> line_din=FFFF0000 at x=5.
REQ-030 Layers 0 and 2 both opaque at x=10 with colours A and B -> B is written. With layer-2 idx=0 -> A is written.
REQ-031 scroll_x=511 and x=0 -> wx=1, checked on map_addr; with hflip=1, tile_addr[2:0]=6.
REQ-032 pal_mode=1, pal_bank=2, map_dout[15:12]=7, idx=8'h25 -> pal_addr=10'h275.
REQ-033 A second start while busy is ignored. rst_n pulled low at x=100 drops busy and writes asynchronously, no done follows, and a following start completes normally.
